stream_max_reduce: RTL and testbench



---
 rtl/stream_max_pkg.sv | 19 +
 rtl/max_u.sv | 24 ++
 rtl/stream_max_reduce.sv | 133 +++++++++++++
 tb/tb_stream_max_reduce.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_max_pkg.sv
// rtl/stream_max_pkg.sv - shared defaults, FSM states and count saturation for stream_max_reduce
// Contents:
//   DEF_WIDTH / DEF_CNT_W : default data and counter widths
//   DEF_CNT_SAT           : saturation value of a default-width counter
//   state_t               : reduction FSM states (ST_EMPTY, ST_ACCUM, ST_DONE)
package stream_max_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  localparam logic [DEF_CNT_W-1:0] DEF_CNT_SAT = '1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/max_u.sv
// rtl/max_u.sv - combinational two-operand unsigned max with greater-than flag
// Ports:
//   i_a  : first operand (the incoming word)
//   i_b  : second operand (the running maximum)
//   o_y  : max(i_a, i_b); i_b on a tie
//   o_gt : 1 when i_a is strictly greater than i_b
module max_u #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y,
  output logic             o_gt
);

  logic w_sel;

  assign w_sel = (i_a > i_b);

  // XOR-mux: with w_sel low the a^b term is masked off and b passes through.
  assign o_y  = ((i_a ^ i_b) & {WIDTH{w_sel}}) ^ i_b;
  assign o_gt = w_sel;

endmodule

// File: rtl/stream_max_reduce.sv
// rtl/stream_max_reduce.sv - per-frame unsigned maximum over a valid/ready word stream
// Optional feature: define MAX_INDEX_EN to add the out_index port and index tracking.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last : word input handshake, in_last closes the frame
//   out_valid/out_ready           : result handshake, result held until taken
//   out_max                       : maximum of the frame
//   out_count                     : words in the frame, saturating at all-ones
//   out_index                     : zero-based position of the first maximum (MAX_INDEX_EN)
module stream_max_reduce
  import stream_max_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [CNT_W-1:0] out_count
`ifdef MAX_INDEX_EN
  ,
  output logic [CNT_W-1:0] out_index
`endif
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_acc_max;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic [WIDTH-1:0] w_max_y;
  logic             w_gt;

  // Acceptance depends only on the state register, so in_ready never
  // sees out_ready combinationally.
  assign in_ready = (r_state != ST_DONE);
  assign w_accept = in_valid && (r_state != ST_DONE);

  max_u #(
    .WIDTH(WIDTH)
  ) u_max (
    .i_a (in_data),
    .i_b (r_acc_max),
    .o_y (w_max_y),
    .o_gt(w_gt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_next = in_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_accept && in_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = ST_EMPTY;
        end
      end
      default: begin
        w_next = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_max <= '0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      if (r_state == ST_EMPTY) begin
        r_acc_max <= in_data;
        r_cnt     <= CNT_W'(1);
      end else begin
        // Strict greater-than keeps the earlier word on a tie.
        if (w_gt) begin
          r_acc_max <= w_max_y;
        end
        if (r_cnt != CNT_SAT) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

`ifdef MAX_INDEX_EN
  logic [CNT_W-1:0] r_idx;

  // The pre-increment count is the zero-based position of the word being
  // folded in; past saturation it stops advancing and the index goes stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_accept) begin
      if (r_state == ST_EMPTY) begin
        r_idx <= '0;
      end else if (w_gt) begin
        r_idx <= r_cnt;
      end
    end
  end

  assign out_index = r_idx;
`endif

  assign out_max   = r_acc_max;
  assign out_count = r_cnt;

endmodule

// File: tb/tb_stream_max_reduce.sv
// tb/tb_stream_max_reduce.sv - randomized self-checking bench for stream_max_reduce
module tb_stream_max_reduce;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_max;
  logic [15:0] out_count;
`ifdef MAX_INDEX_EN
  logic [15:0] out_index;
`endif

  logic        s_in_valid;
  logic        s_in_ready;
  logic [31:0] s_in_data;
  logic        s_in_last;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_out_max;
  logic [1:0]  s_out_count;
`ifdef MAX_INDEX_EN
  logic [1:0]  s_out_index;
`endif

  int n_vec = 0;
  int n_err = 0;

  stream_max_reduce dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max  (out_max),
    .out_count(out_count)
`ifdef MAX_INDEX_EN
    ,
    .out_index(out_index)
`endif
  );

  stream_max_reduce #(
    .WIDTH(32),
    .CNT_W(2)
  ) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_data  (s_in_data),
    .in_last  (s_in_last),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_max  (s_out_max),
    .out_count(s_out_count)
`ifdef MAX_INDEX_EN
    ,
    .out_index(s_out_index)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain max over the frame, first occurrence, saturating length.
  function automatic void ref_frame(input logic [31:0] w[$], output logic [31:0] m,
                                    output logic [15:0] c, output logic [15:0] ix);
    m  = w[0];
    ix = 0;
    for (int i = 1; i < w.size(); i++) begin
      if (w[i] > m) begin
        m  = w[i];
        ix = 16'(i);
      end
    end
    c = (w.size() > 65535) ? 16'hFFFF : 16'(w.size());
  endfunction

  // Called just after a rising edge; returns just after the edge that accepts the word.
  task automatic put_word(input logic [31:0] d, input bit last, output int waited);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom);
  endtask

  task automatic get_result(input logic [31:0] em, input logic [15:0] ec,
                            input logic [15:0] ei, input int hold);
    int t;
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    chk("done_in_ready", in_ready, 0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      chk("valid_timeout", out_valid, 1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_max", out_max, em);
      chk("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    chk("out_max", out_max, em);
    chk("out_count", out_count, ec);
`ifdef MAX_INDEX_EN
    chk("out_index", out_index, ei);
`else
    if (ei > 16'hFFFF) chk("index_range", ei, 0);
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] w[$], input int hold, input bit gaps);
    logic [31:0] em;
    logic [15:0] ec;
    logic [15:0] ei;
    int          wt;
    ref_frame(w, em, ec, ei);
    for (int i = 0; i < w.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      put_word(w[i], (i == w.size() - 1), wt);
    end
    get_result(em, ec, ei, hold);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] em;
    logic [15:0] ec;
    logic [15:0] ei;
    int          wt;

    rst = 1'b1;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    s_in_valid = 0; s_in_data = 0; s_in_last = 0; s_out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_max", out_max, 0);
    chk("rst_out_count", out_count, 0);
`ifdef MAX_INDEX_EN
    chk("rst_out_index", out_index, 0);
`endif
    @(posedge clk);
    #1;

    q = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd2};
    run_frame(q, 0, 0);
    q = '{32'hFFFF_FFFF};
    run_frame(q, 0, 0);
    q = '{32'h8000_0000, 32'h7FFF_FFFF};
    run_frame(q, 0, 0);

    // Stall in DONE with a word waiting; it must be taken only after the handshake.
    put_word(32'd1, 0, wt);
    put_word(32'd3, 0, wt);
    put_word(32'd2, 1, wt);
    in_valid = 1'b1; in_data = 32'hDEAD; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_max", out_max, 32'd3);
      chk("stall_count", out_count, 16'd3);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_in_ready", in_ready, 1);
    chk("b2b_valid_low", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    get_result(32'hDEAD, 16'd1, 16'd0, 0);

    // Asynchronous reset mid-frame.
    put_word(32'd50, 0, wt);
    put_word(32'd60, 0, wt);
    put_word(32'd70, 0, wt);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_max", out_max, 0);
    chk("arst_out_count", out_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    q = '{32'd4, 32'd1};
    run_frame(q, 0, 0);

    // Randomized frames with input gaps and output stalls.
    for (int f = 0; f < 40; f++) begin
      int len;
      int mode;
      len  = $urandom_range(1, 8);
      mode = $urandom_range(0, 3);
      q = {};
      for (int i = 0; i < len; i++) begin
        case (mode)
          1: q.push_back(32'($urandom_range(0, 3)));
          2: begin
            case ($urandom_range(0, 3))
              0: q.push_back(32'h0);
              1: q.push_back(32'hFFFF_FFFF);
              2: q.push_back(32'h8000_0000);
              default: q.push_back(32'h7FFF_FFFF);
            endcase
          end
          default: q.push_back($urandom);
        endcase
      end
      run_frame(q, $urandom_range(0, 3), 1'($urandom));
    end

    // Saturating counter on the narrow instance: 6 x 7 then 8.
    for (int i = 0; i < 7; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = (i < 6) ? 32'd7 : 32'd8;
      s_in_last  = (i == 6);
      @(negedge clk);
      chk("sat_in_ready", s_in_ready, 1);
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    chk("sat_valid", s_out_valid, 1);
    chk("sat_max", s_out_max, 32'd8);
    chk("sat_count", s_out_count, 2'd3);
    s_out_ready = 1'b1;
    @(posedge clk);
    #1;
    s_out_ready = 1'b0;
    @(negedge clk);
    chk("sat_release", s_out_valid, 0);

    ref_frame('{32'd1}, em, ec, ei);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
